// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot responder.
//   state_t   : loader/run FSM states
//   NOP_INSTR : word returned when no valid instruction is available
//   COUNT_W   : width of the header word count
package imem_boot_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          COUNT_W   = 16;
endpackage

// File: rtl/imem_boot_ram.sv
// 1-write / 1-read synchronous instruction RAM, DEPTH x 32, registered read.
// No reset on the array or the read register, so it maps onto block RAM.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address (sampled at the clock edge)
//   rdata_o : read data, valid one cycle after raddr_i is sampled
module imem_boot_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_boot_responder.sv
// Instruction-side responder for the MIPS core. Loads a program from a
// valid/ready byte stream (16-bit LE word count, then LE words) into its
// RAM while holding the core in reset, then serves 1-cycle-latency fetches.
//   clk, rst_n          : clock, synchronous active-low reset
//   byte_valid/data     : loader byte stream in
//   byte_ready          : byte accepted this cycle (HDR0/HDR1/DATA)
//   reload_req          : restart loading from RUN or ERR
//   fetch_addr          : word address from the core
//   instruction_o       : fetched instruction (NOP outside RUN / out of range)
//   cpu_rst_n           : core reset, released when the load completes
//   load_done, load_err : in RUN / in ERR
module imem_boot_responder
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       instruction_o,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(2**ADDR_W);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;      // {b2,b1,b0} once three bytes are in
  logic                cpu_rst_q;
  logic                sel_q, sel_d;      // registered "rdata is a real instruction"
  logic                xfer, we, last_word, in_range;
  logic [COUNT_W-1:0]  hdr_cnt;
  logic [31:0]         rdata;

  assign byte_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
  assign xfer       = byte_valid && byte_ready;
  assign hdr_cnt    = {byte_data, count_q[7:0]};
  assign last_word  = (COUNT_W'(wr_ptr_q) == count_q - 1'b1);
  assign in_range   = (COUNT_W'(fetch_addr) < count_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we         = 1'b0;
    case (state_q)
      HDR0: if (xfer) begin
        count_d[7:0] = byte_data;
        state_d      = HDR1;
      end
      HDR1: if (xfer) begin
        count_d    = hdr_cnt;
        wr_ptr_d   = '0;
        byte_idx_d = '0;
        state_d    = (hdr_cnt == '0 || hdr_cnt > DEPTH_C) ? ERR : DATA;
      end
      DATA: if (xfer) begin
        // Bytes shift in from the top so b0 ends up in the low byte.
        asm_d      = {byte_data, asm_q[23:8]};
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          we = 1'b1;
          if (last_word) state_d  = RUN;
          else           wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      RUN, ERR: if (reload_req) state_d = HDR0;
      default: state_d = HDR0;
    endcase
  end

  // Only serve fetches sampled while staying in RUN; reload wins over fetch.
  assign sel_d = (state_q == RUN) && (state_d == RUN) && in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HDR0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      cpu_rst_q  <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      cpu_rst_q  <= (state_d == RUN);
      sel_q      <= sel_d;
    end
  end

  imem_boot_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({byte_data, asm_q}),
    .raddr_i (fetch_addr),
    .rdata_o (rdata)
  );

  assign instruction_o = sel_q ? rdata : NOP_INSTR;
  assign cpu_rst_n     = cpu_rst_q;
  assign load_done     = (state_q == RUN);
  assign load_err      = (state_q == ERR);
endmodule

// File: tb/tb_imem_boot_responder.sv
module tb_imem_boot_responder;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h0;
  logic              byte_ready;
  logic              reload_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [31:0]       instruction_o;
  logic              cpu_rst_n, load_done, load_err;

  imem_boot_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload_req(reload_req), .fetch_addr(fetch_addr),
    .instruction_o(instruction_o), .cpu_rst_n(cpu_rst_n),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  // Reference model: program image, word count, and whether the core runs.
  logic [31:0] m_mem [DEPTH];
  int          m_n = 0;
  bit          m_run = 0;
  logic [31:0] wq[$];

  function automatic logic [31:0] exp_fetch(input int a);
    return (m_run && a < m_n) ? m_mem[a] : 32'h0;
  endfunction

  // Present one byte after 'gap' idle cycles and wait for it to be taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20; t++) begin
      rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy) begin
        xfers++;
        byte_valid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_byte_timeout byte=%h not accepted in 20 cycles", b);
    byte_valid = 1'b0;
  endtask

  // Stream the words in wq as a full load and update the model.
  task automatic load_words(input int max_gap);
    int n;
    n = wq.size();
    m_run = 0;
    send_byte(n[7:0], $urandom_range(max_gap));
    send_byte(n[15:8], $urandom_range(max_gap));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++)
        send_byte(wq[i][8*k +: 8], $urandom_range(max_gap));
    for (int i = 0; i < n; i++) m_mem[i] = wq[i];
    m_n = n;
    m_run = 1;
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    @(posedge clk); #1;
    reload_req = 1'b0;
    m_run = 0;
  endtask

  task automatic fetch_chk(input int a);
    logic [31:0] e;
    fetch_addr = a[ADDR_W-1:0];
    @(posedge clk); #1;
    e = exp_fetch(a);
    total++;
    if (instruction_o !== e) begin
      bad++;
      $display("FAIL fetch addr=%0d got=%h exp=%h", a, instruction_o, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if ({byte_ready, cpu_rst_n, load_done, load_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=1000", {byte_ready, cpu_rst_n, load_done, load_err});
    end
    total++;
    if (instruction_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_instr got=%h exp=0", instruction_o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bs [10];
    bs = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h03, 8'h20, 8'hAC, 8'h03, 8'h00, 8'h03};
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      send_byte(bs[i], 0);
      if (i == 8) begin
        total++;
        if (cpu_rst_n !== 1'b0) begin
          bad++;
          $display("FAIL basic_early_release got=%b exp=0", cpu_rst_n);
        end
      end
    end
    total++;
    if ({cpu_rst_n, load_done, byte_ready} !== 3'b110) begin
      bad++;
      $display("FAIL basic_release got=%b exp=110", {cpu_rst_n, load_done, byte_ready});
    end
    total++;
    if (xfers !== 10) begin
      bad++;
      $display("FAIL basic_xfers got=%0d exp=10", xfers);
    end
    m_mem[0] = 32'h20030020; m_mem[1] = 32'h030003AC; m_n = 2; m_run = 1;
    // Bytes offered in RUN must be ignored.
    byte_valid = 1'b1; byte_data = 8'hFF;
    total++;
    if (byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL run_ready got=%b exp=0", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    fetch_chk(0);
    fetch_chk(1);
  endtask

  task automatic test_oob();
    fetch_chk(5);
    fetch_chk(0);
    fetch_chk(0);
    fetch_chk(1);
    fetch_chk(0);
    fetch_chk(DEPTH - 1);
  endtask

  task automatic test_hdr_err();
    pulse_reload();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    total++;
    if ({load_err, byte_ready, cpu_rst_n, load_done} !== 4'b1000) begin
      bad++;
      $display("FAIL hdr_over got=%b exp=1000", {load_err, byte_ready, cpu_rst_n, load_done});
    end
    fetch_chk(0);
    pulse_reload();
    total++;
    if ({load_err, byte_ready} !== 2'b01) begin
      bad++;
      $display("FAIL err_reload got=%b exp=01", {load_err, byte_ready});
    end
    fill_random(3);
    load_words(0);
    total++;
    if ({cpu_rst_n, load_done, load_err} !== 3'b110) begin
      bad++;
      $display("FAIL err_recover got=%b exp=110", {cpu_rst_n, load_done, load_err});
    end
    fetch_chk(2);
    fetch_chk(3);
    pulse_reload();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++;
    if ({load_err, cpu_rst_n} !== 2'b10) begin
      bad++;
      $display("FAIL hdr_zero got=%b exp=10", {load_err, cpu_rst_n});
    end
    // N == DEPTH is the largest legal count.
    pulse_reload();
    fill_random(DEPTH);
    load_words(0);
    total++;
    if ({load_done, load_err} !== 2'b10) begin
      bad++;
      $display("FAIL full_depth got=%b exp=10", {load_done, load_err});
    end
    fetch_chk(DEPTH - 1);
    for (int i = 0; i < 8; i++) fetch_chk($urandom_range(DEPTH - 1));
  endtask

  task automatic test_gapped();
    for (int r = 0; r < 3; r++) begin
      pulse_reload();
      fill_random(4);
      load_words(3);
      for (int a = 0; a < 8; a++) fetch_chk(a);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reload();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) send_byte($urandom, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_run = 0;
    total++;
    if ({byte_ready, cpu_rst_n, load_done, load_err} !== 4'b1000 || instruction_o !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h exp=1000/0", {byte_ready, cpu_rst_n, load_done, load_err}, instruction_o);
    end
    wq.delete(); wq.push_back(32'hDEADBEEF);
    load_words(0);
    fetch_chk(0);
    fetch_chk(1);
  endtask

  task automatic test_reload();
    pulse_reload();
    fill_random(4);
    load_words(1);
    fetch_chk(1);
    // Reload and a fetch in the same cycle: reload wins.
    fetch_addr = '0;
    reload_req = 1'b1;
    @(posedge clk); #1;
    reload_req = 1'b0;
    m_run = 0;
    total++;
    if ({cpu_rst_n, load_done, byte_ready} !== 3'b001 || instruction_o !== 32'h0) begin
      bad++;
      $display("FAIL reload_run got=%b/%h exp=001/0", {cpu_rst_n, load_done, byte_ready}, instruction_o);
    end
    fill_random(1);
    load_words(2);
    fetch_chk(1);
    fetch_chk(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oob();
    test_hdr_err();
    test_gapped();
    test_reset_mid();
    test_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_boot_responder.md
# imem_boot_responder

Instruction-side responder for the 5-stage MIPS core. It sits on the far end of the core's fetch interface: it takes the word fetch address and returns the instruction word one clock later. Before execution starts, it loads program words from an 8-bit valid/ready byte stream into its own instruction RAM, holding the core in reset until the load completes. It replaces a fixed ROM, so programs can be reloaded without resynthesis.

## Interface
Parameters:
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- byte_valid  in  1  loader byte present.
- byte_data  in  8  loader byte.
- byte_ready  out  1  responder accepts a byte this cycle.
- reload_req  in  1  single-cycle pulse; restarts loading from RUN or ERR.
- fetch_addr  in  ADDR_W  word address from the core (byte PC >> 2).
- instruction_o  out  32  fetched instruction, registered.
- cpu_rst_n  out  1  core reset, synchronous, active-low; low until load completes.
- load_done  out  1  high in RUN.
- load_err  out  1  high in ERR.

## Operation
- Byte transfer: occurs when byte_valid && byte_ready on a rising clk edge. byte_ready = 1 only in HDR0, HDR1 and DATA.
- Stream format:
  - Bytes 0–1: word count N, little-endian (HDR0 = low byte, HDR1 = high byte).
  - Then N×4 instruction bytes, each word little-endian: word = {b3,b2,b1,b0}.
- States:
  - HDR0: accept low count byte → HDR1.
  - HDR1: accept high count byte. If N == 0 or N > DEPTH → ERR. Otherwise → DATA, with wr_ptr = 0 and byte_idx = 0.
  - DATA: shift the byte into the assembly register and increment byte_idx (2-bit).
    - On the byte with byte_idx == 3, write {byte, b2, b1, b0} to mem[wr_ptr] at that edge.
    - If wr_ptr == N−1 → RUN; else increment wr_ptr.
  - RUN: byte_ready = 0 and incoming bytes are ignored. reload_req → HDR0.
  - ERR: byte_ready = 0. reload_req → HDR0.
- reload_req is ignored in HDR0, HDR1 and DATA.
- Fetch:
  - In RUN: instruction_o <= (fetch_addr < N) ? mem[fetch_addr] : 32'h0. Addresses at or above N return NOP.
  - In all other states: instruction_o <= 32'h0.
- The RAM array is not reset. Words at or above N keep stale contents but are never returned.
- cpu_rst_n is registered: cpu_rst_n <= (next_state == RUN).
- Reset mid-load: state, counters and outputs go to their reset values. Partially written RAM is left as is. The next load overwrites from address 0.

## Timing
- Reset values:
  - state = HDR0.
  - byte_ready = 1 in the first cycle after reset (derived combinationally from state).
  - instruction_o = 0, cpu_rst_n = 0, load_done = 0, load_err = 0.
  - Internal: N = 0, wr_ptr = 0, byte_idx = 0.
- Load length: 2 + 4N accepted bytes. Back-to-back valid gives no bubbles.
- Release: the edge that accepts the last byte sets state = RUN, cpu_rst_n = 1 and load_done = 1 together.
- Fetch latency: exactly 1 cycle (fetch_addr sampled at edge k, instruction_o valid after edge k). This matches the core's IF/ID register sampling instruction_i.
- A reload_req pulse in RUN: at that edge cpu_rst_n → 0, load_done → 0 and state → HDR0. instruction_o is 0 from the next edge.
- Simultaneous reload_req and fetch: reload wins, and instruction_o <= 0.
- load_err is asserted at the edge that accepts the second header byte.

## Structure
- Package imem_boot_pkg:
  - state_t enum {HDR0, HDR1, DATA, RUN, ERR}.
  - NOP_INSTR = 32'h0.
  - COUNT_W = 16.
- Sub-module imem_boot_ram: 1 write / 1 read synchronous RAM, registered read, DEPTH×32. Must infer block RAM.
- The top module holds the FSM, header/count registers, byte assembly, wr_ptr, the fetch-range check and the cpu_rst_n register.

## Test plan
- Basic load: bytes 02 00 20 00 03 20 AC 03 00 03 with valid held high.
  - Exactly 10 transfers.
  - cpu_rst_n rises at the edge accepting the 10th byte.
  - fetch_addr = 0 → 0x20030020 next cycle; fetch_addr = 1 → 0x030003AC.
- Out-of-range fetch after that load: fetch_addr = 5 → instruction_o = 0. fetch_addr = 0 on consecutive cycles gives steady 0x20030020 with 1-cycle latency.
- Header errors:
  - Count 0x0041 with ADDR_W = 6 (N = 65 > DEPTH = 64) → load_err = 1, byte_ready = 0, cpu_rst_n stays 0.
  - reload_req then a valid stream → normal completion.
  - Count 0 → ERR.
- Gapped byte_valid: random idle cycles between bytes of a 4-word load → same RAM contents as the gap-free load. byte_idx does not advance on idle cycles.
- Reset mid-load: rst_n low after 5 bytes → HDR0, all outputs at reset values. A fresh 1-word load of 0xDEADBEEF (bytes EF BE AD DE) → fetch 0 returns 0xDEADBEEF and fetch 1 returns 0.
- Reload in RUN: reload_req → cpu_rst_n 0 at that edge and instruction_o 0. New 1-word load → fetch 1 returns 0 even though old data remains at address 1.
